// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change amount as 50/10/5/1 coins, one coin at a time. Each coin
// is a one-cycle pulse to its hopper, and the next coin waits for the
// hopper's drop acknowledge. Each denomination has a stock counter. When a
// hopper is empty, the payout falls back to smaller coins.
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; refill allowed
// SELECT   | choose the largest coin that fits remaining and is in stock
// PULSE    | coin pulse on the chosen hopper, stock decremented
// WAIT_ACK | waiting for mech_ack, bounded by ACK_TIMEOUT
// DONE     | one-cycle done, beep counter loaded
// ERR      | out of suitable coins or hopper fault; refill/start allowed
//
// Ports:
//   clk_sys, rst            clock, synchronous active-high reset
//   start, amount           payout request and its value (8-bit units)
//   mech_ack                hopper drop acknowledge
//   refill                  reload all stock counters (IDLE/ERR only)
//   qian50/10/5/1           one-cycle coin pulses
//   busy, done, err         status to the seller core
//   remaining               value not yet paid out
//   beep                    completion tone
module change_dispenser #(
    parameter logic [7:0] STOCK50_INIT = 8'd20,
    parameter logic [7:0] STOCK10_INIT = 8'd50,
    parameter logic [7:0] STOCK5_INIT  = 8'd50,
    parameter logic [7:0] STOCK1_INIT  = 8'd100,
    parameter int         ACK_TIMEOUT  = 16,
    parameter int         BEEP_CYCLES  = 8
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       mech_ack,
    input  logic       refill,
    output logic       qian50,
    output logic       qian10,
    output logic       qian5,
    output logic       qian1,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] remaining,
    output logic       beep
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, DONE, ERR} state_t;

    state_t        state;
    logic [7:0]    stock50, stock10, stock5, stock1;
    logic [3:0]    coin_sel;      // one-hot {50,10,5,1}
    logic [7:0]    coin_val;
    logic [TW-1:0] timeout_cnt;
    logic [BW-1:0] beep_cnt;

    logic          pick_ok;
    logic [3:0]    pick_sel;
    logic [7:0]    pick_val;

    // Greedy choice: largest denomination that fits and is still stocked.
    always_comb begin
        pick_ok  = 1'b0;
        pick_sel = 4'b0000;
        pick_val = 8'd0;
        if (remaining >= 8'd50 && stock50 != 8'd0) begin
            pick_ok = 1'b1; pick_sel = 4'b1000; pick_val = 8'd50;
        end else if (remaining >= 8'd10 && stock10 != 8'd0) begin
            pick_ok = 1'b1; pick_sel = 4'b0100; pick_val = 8'd10;
        end else if (remaining >= 8'd5 && stock5 != 8'd0) begin
            pick_ok = 1'b1; pick_sel = 4'b0010; pick_val = 8'd5;
        end else if (remaining >= 8'd1 && stock1 != 8'd0) begin
            pick_ok = 1'b1; pick_sel = 4'b0001; pick_val = 8'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state       <= IDLE;
            stock50     <= STOCK50_INIT;
            stock10     <= STOCK10_INIT;
            stock5      <= STOCK5_INIT;
            stock1      <= STOCK1_INIT;
            coin_sel    <= 4'b0000;
            coin_val    <= 8'd0;
            timeout_cnt <= '0;
            beep_cnt    <= '0;
            qian50      <= 1'b0;
            qian10      <= 1'b0;
            qian5       <= 1'b0;
            qian1       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            remaining   <= 8'd0;
            beep        <= 1'b0;
        end else begin
            // Coin pulses and done are single-cycle by default.
            {qian50, qian10, qian5, qian1} <= 4'b0000;
            done <= 1'b0;

            // Beep runs on its own so a new payout can start during the tone.
            if (beep_cnt != '0) begin
                beep_cnt <= beep_cnt - BW'(1);
                beep     <= 1'b1;
            end else begin
                beep     <= 1'b0;
            end

            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        remaining <= amount;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        state     <= SELECT;
                    end else if (refill) begin
                        stock50 <= STOCK50_INIT;
                        stock10 <= STOCK10_INIT;
                        stock5  <= STOCK5_INIT;
                        stock1  <= STOCK1_INIT;
                    end
                end
                SELECT: begin
                    if (remaining == 8'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (pick_ok) begin
                        coin_sel <= pick_sel;
                        coin_val <= pick_val;
                        // Registered here so the pulse lines up with PULSE.
                        {qian50, qian10, qian5, qian1} <= pick_sel;
                        state <= PULSE;
                    end else begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end
                end
                PULSE: begin
                    if (coin_sel[3] && stock50 != 8'd0) stock50 <= stock50 - 8'd1;
                    if (coin_sel[2] && stock10 != 8'd0) stock10 <= stock10 - 8'd1;
                    if (coin_sel[1] && stock5  != 8'd0) stock5  <= stock5  - 8'd1;
                    if (coin_sel[0] && stock1  != 8'd0) stock1  <= stock1  - 8'd1;
                    timeout_cnt <= '0;
                    state       <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (mech_ack) begin
                        remaining <= remaining - coin_val;
                        state     <= SELECT;
                    end else if (timeout_cnt == TO_LAST) begin
                        // The dropped-or-not coin stays counted out of stock.
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    beep     <= 1'b1;
                    beep_cnt <= BEEP_LOAD;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
